// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared index-width, pointer-increment and data-slicing helpers for rr_mux_nto1
package rr_mux_pkg;
   localparam int DEF_N_CH = 8;
   localparam int DEF_DW   = 8;
   typedef logic [DEF_N_CH-1:0][DEF_DW-1:0] ch_data_t;
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
   function automatic int inc_mod(input int v, input int n);
      return (v >= n - 1) ? 0 : v + 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search, first requester at or after i_ptr with wrap
module rr_arbiter import rr_mux_pkg::*; #(
   parameter int N_CH = 8,
   localparam int IW = idx_w(N_CH)
) (
   input  logic [N_CH-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [N_CH-1:0] o_grant,
   output logic [IW-1:0]   o_g
);
   logic w_found;
   int   w_idx;
   always_comb begin
      o_grant = '0;
      o_g     = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < N_CH; k++) begin
         w_idx = int'(i_ptr) + k;
         w_idx = (w_idx >= N_CH) ? w_idx - N_CH : w_idx;
         if (!w_found && i_req[w_idx]) begin
            w_found        = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_g            = IW'(w_idx);
         end
      end
   end
endmodule

// File: rtl/rr_mux_nto1.sv
// rr_mux_nto1: registered round-robin N-to-1 mux with valid/ready; RR_MUX_PKT_LOCK_EN adds in_last packet lock
module rr_mux_nto1 import rr_mux_pkg::*; #(
   parameter int N_CH = 8,
   parameter int DW   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          in_valid,
   input  logic [N_CH*DW-1:0]       in_data,
`ifdef RR_MUX_PKT_LOCK_EN
   input  logic [N_CH-1:0]          in_last,
`endif
   output logic [N_CH-1:0]          in_ready,
   output logic                     out_valid,
   output logic [DW-1:0]            out_data,
   output logic [idx_w(N_CH)-1:0]   out_ch,
   input  logic                     out_ready
);
   localparam int IW = idx_w(N_CH);
   typedef logic [N_CH-1:0][DW-1:0] ch_slice_t;
   ch_slice_t       w_data;
   logic [N_CH-1:0] w_req;
   logic [N_CH-1:0] w_grant;
   logic [IW-1:0]   w_g;
   logic [IW-1:0]   w_ptr_nxt;
   logic            w_load;
   logic            w_any;
   logic            w_acc;
   logic [IW-1:0]   r_ptr;
   logic            r_out_valid;
   logic [DW-1:0]   r_out_data;
   logic [IW-1:0]   r_out_ch;
   assign w_data    = in_data;
   assign w_load    = !r_out_valid || out_ready;
   assign w_any     = |w_req;
   assign w_acc     = w_load && w_any;
   assign w_ptr_nxt = IW'(inc_mod(int'(w_g), N_CH));
   assign in_ready  = w_acc ? w_grant : '0;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
`ifdef RR_MUX_PKT_LOCK_EN
   logic            r_lock;
   logic [IW-1:0]   r_lock_ch;
   logic [N_CH-1:0] w_lock_mask;
   // while locked only the owning channel may compete, idle or not
   assign w_lock_mask = N_CH'(1) << r_lock_ch;
   assign w_req       = r_lock ? (in_valid & w_lock_mask) : in_valid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock    <= 1'b0;
         r_lock_ch <= '0;
      end else if (w_acc) begin
         r_lock    <= !in_last[w_g];
         r_lock_ch <= w_g;
      end
   end
`else
   assign w_req = in_valid;
`endif
   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_g     (w_g)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_ptr       <= '0;
      end else if (w_load) begin
         r_out_valid <= w_any;
         if (w_any) begin
            r_out_data <= w_data[w_g];
            r_out_ch   <= w_g;
`ifdef RR_MUX_PKT_LOCK_EN
            if (in_last[w_g]) r_ptr <= w_ptr_nxt;
`else
            r_ptr <= w_ptr_nxt;
`endif
         end
      end
   end
endmodule

// File: tb/tb_rr_mux_nto1.sv
// tb_rr_mux_nto1: randomized and directed checks of rr_mux_nto1 against a behavioural round-robin model
module tb_rr_mux_nto1;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_valid;
   logic [63:0] in_data;
   logic [7:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  out_ch;
   logic        out_ready;
   logic [4:0]  v5;
   logic [39:0] d5;
   logic [4:0]  r5;
   logic        ov5;
   logic [7:0]  od5;
   logic [2:0]  oc5;
   logic        ordy5 = 1'b1;
`ifdef RR_MUX_PKT_LOCK_EN
   logic [7:0]  in_last;
   logic [4:0]  l5 = '1;
`endif
   int          n_tests = 0;
   int          n_fail = 0;
   int          m_ptr;
   bit          m_ov;
   logic [7:0]  m_od;
   logic [2:0]  m_oc;
   bit          m_lock;
   int          m_lch;

   always #5 clk = ~clk;

   rr_mux_nto1 #(.N_CH(8), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef RR_MUX_PKT_LOCK_EN
      .in_last(in_last),
`endif
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ch(out_ch), .out_ready(out_ready)
   );

   rr_mux_nto1 #(.N_CH(5), .DW(8)) dut5 (
      .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_data(d5),
`ifdef RR_MUX_PKT_LOCK_EN
      .in_last(l5),
`endif
      .in_ready(r5), .out_valid(ov5), .out_data(od5),
      .out_ch(oc5), .out_ready(ordy5)
   );

   // model: channel chosen is the first valid one scanning upward from ptr modulo 8
   function automatic int m_pick();
      if (m_lock) return in_valid[m_lch] ? m_lch : -1;
      for (int k = 0; k < 8; k++) if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
      return -1;
   endfunction

   function automatic logic [7:0] m_ready();
      int g = m_pick();
      return ((!m_ov || out_ready) && g >= 0) ? 8'(1 << g) : 8'h00;
   endfunction

   task automatic m_reset();
      m_ptr = 0; m_ov = 0; m_od = 0; m_oc = 0; m_lock = 0; m_lch = 0;
   endtask

   task automatic tick();
      int g;
      bit ld;
      g  = m_pick();
      ld = !m_ov || out_ready;
      @(posedge clk);
      if (ld) begin
         m_ov = (g >= 0);
         if (g >= 0) begin
            m_od = in_data[g*8 +: 8];
            m_oc = 3'(g);
`ifdef RR_MUX_PKT_LOCK_EN
            if (in_last[g]) begin m_lock = 0; m_ptr = (g + 1) % 8; end
            else begin m_lock = 1; m_lch = g; end
`else
            m_ptr = (g + 1) % 8;
`endif
         end
      end
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0; v5 = 0;
      rst_n = 0;
      #1;
      rst_n = 1;
      m_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%0h exp=00", out_data); end
      n_tests++; if (out_ch !== 3'd0) begin n_fail++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
      rst_n = 1;
      m_reset();
      @(posedge clk);
      #1;
      in_valid = 8'h01; in_data[7:0] = 8'h3C; out_ready = 0;
      tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got=%0b exp=1", out_valid); end
      rst_n = 0;
      #1;
      n_tests++; if ({out_valid, out_data, out_ch} !== 12'h000) begin n_fail++; $display("FAIL async_reset got=%0b/%0h/%0d exp=0/00/0", out_valid, out_data, out_ch); end
      in_valid = 0;
      #1;
      rst_n = 1;
      m_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      in_valid = 8'h04; in_data = {$urandom, $urandom}; in_data[23:16] = 8'hA5; out_ready = 1;
      #1;
      n_tests++; if (in_ready !== 8'h04) begin n_fail++; $display("FAIL single_ready got=%0h exp=04", in_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
      n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%0h exp=a5", out_data); end
      n_tests++; if (out_ch !== 3'd2) begin n_fail++; $display("FAIL single_ch got=%0d exp=2", out_ch); end
   endtask

   task automatic test_fairness();
      logic [7:0] seen = 0;
      do_reset();
      for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(i);
      in_valid = 8'hFF; out_ready = 1;
      for (int k = 0; k < 9; k++) begin
         tick();
         n_tests++; if (out_ch !== 3'(k % 8) || out_data !== 8'(k % 8)) begin n_fail++; $display("FAIL fair_seq[%0d] got=%0d/%0h exp=%0d", k, out_ch, out_data, k % 8); end
         if (k < 8) begin
            n_tests++; if (seen[out_ch] !== 1'b0) begin n_fail++; $display("FAIL fair_twice ch=%0d got=1 exp=0", out_ch); end
            seen[out_ch] = 1'b1;
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] d0;
      logic [2:0] c0;
      in_valid = 8'hFF; out_ready = 1;
      tick();
      out_ready = 0;
      d0 = out_data; c0 = out_ch;
      for (int k = 0; k < 5; k++) begin
         in_data = {$urandom, $urandom};
         #1;
         n_tests++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_ready got=%0h exp=00", in_ready); end
         tick();
         n_tests++; if (out_valid !== 1'b1 || out_data !== d0 || out_ch !== c0) begin n_fail++; $display("FAIL bp_hold got=%0b/%0h/%0d exp=1/%0h/%0d", out_valid, out_data, out_ch, d0, c0); end
      end
      out_ready = 1;
      #1;
      n_tests++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL bp_release_ready got=%0h exp=%0h", in_ready, m_ready()); end
      tick();
      n_tests++; if (out_ch !== m_oc || out_data !== m_od) begin n_fail++; $display("FAIL bp_release got=%0d/%0h exp=%0d/%0h", out_ch, out_data, m_oc, m_od); end
   endtask

   task automatic test_wrap();
      do_reset();
      out_ready = 1; in_valid = 8'h20;
      tick();
      in_valid = 8'h03;
      #1;
      n_tests++; if (in_ready !== 8'h01) begin n_fail++; $display("FAIL wrap_first got=%0h exp=01", in_ready); end
      tick();
      n_tests++; if (out_ch !== 3'd0) begin n_fail++; $display("FAIL wrap_ch0 got=%0d exp=0", out_ch); end
      #1;
      n_tests++; if (in_ready !== 8'h02) begin n_fail++; $display("FAIL wrap_second got=%0h exp=02", in_ready); end
      tick();
      n_tests++; if (out_ch !== 3'd1) begin n_fail++; $display("FAIL wrap_ch1 got=%0d exp=1", out_ch); end
      in_valid = 8'hFF;
      #1;
      n_tests++; if (in_ready !== 8'h04) begin n_fail++; $display("FAIL wrap_ptr2 got=%0h exp=04", in_ready); end
      tick();
   endtask

   task automatic test_idle();
      logic [7:0] d0;
      out_ready = 1; in_valid = 8'h10; in_data[39:32] = 8'h5E;
      tick();
      n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h5E) begin n_fail++; $display("FAIL idle_load got=%0b/%0h exp=1/5e", out_valid, out_data); end
      d0 = out_data; in_valid = 0;
      #1;
      n_tests++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL idle_ready got=%0h exp=00", in_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b0 || out_data !== d0) begin n_fail++; $display("FAIL idle_drain got=%0b/%0h exp=0/%0h", out_valid, out_data, d0); end
   endtask

`ifdef RR_MUX_PKT_LOCK_EN
   task automatic test_lock();
      do_reset();
      out_ready = 1; in_last = 8'hFF; in_valid = 8'h04;
      tick();
      in_valid = 8'hFF; in_last = 8'hF7;
      for (int b = 0; b < 3; b++) begin
         if (b == 2) in_last = 8'hFF;
         #1;
         n_tests++; if (in_ready !== 8'h08) begin n_fail++; $display("FAIL lock_ready[%0d] got=%0h exp=08", b, in_ready); end
         tick();
         n_tests++; if (out_ch !== 3'd3) begin n_fail++; $display("FAIL lock_ch[%0d] got=%0d exp=3", b, out_ch); end
      end
      tick();
      n_tests++; if (out_ch !== 3'd4) begin n_fail++; $display("FAIL lock_release got=%0d exp=4", out_ch); end
   endtask
`endif

   task automatic test_wrap5();
      do_reset();
      in_valid = 0; out_ready = 1; v5 = 5'h1F;
      for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'(i + 16);
      for (int k = 0; k < 11; k++) begin
         #1;
         n_tests++; if (r5 !== 5'(1 << (k % 5))) begin n_fail++; $display("FAIL wrap5_ready[%0d] got=%0h exp=%0h", k, r5, 5'(1 << (k % 5))); end
         tick();
         n_tests++; if (ov5 !== 1'b1 || oc5 !== 3'(k % 5) || od5 !== 8'(k % 5 + 16)) begin n_fail++; $display("FAIL wrap5_out[%0d] got=%0b/%0d/%0h exp=1/%0d/%0h", k, ov5, oc5, od5, k % 5, k % 5 + 16); end
      end
      v5 = 0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         in_valid  = 8'($urandom);
         if ($urandom_range(0, 4) == 0) in_valid = 0;
         in_data   = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_MUX_PKT_LOCK_EN
         in_last   = 8'($urandom);
`endif
         #1;
         n_tests++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready[%0d] got=%0h exp=%0h", k, in_ready, m_ready()); end
         tick();
         n_tests++; if (out_valid !== m_ov || out_data !== m_od || out_ch !== m_oc) begin n_fail++; $display("FAIL rand_out[%0d] got=%0b/%0h/%0d exp=%0b/%0h/%0d", k, out_valid, out_data, out_ch, m_ov, m_od, m_oc); end
      end
   endtask

   initial begin
      rst_n = 0; in_valid = 0; in_data = 0; out_ready = 0; v5 = 0; d5 = 0;
`ifdef RR_MUX_PKT_LOCK_EN
      in_last = 8'hFF;
`endif
      m_reset();
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_wrap();
      test_idle();
`ifdef RR_MUX_PKT_LOCK_EN
      test_lock();
`endif
      test_wrap5();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
